// File: rtl/tile_scanner.sv
// tile_scanner: VGA raster generator and name-table reader feeding the tile pixel RAM.
// Stage 0 addresses the name table, stage 1 pairs the returned tile number with its
// row/column, and sync/blank are delayed two cycles to line up with the tile RAM pixel.
module tile_scanner #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [8:0]  scroll_x,
    input  logic [8:0]  scroll_y,
    output logic [11:0] name_addr,
    input  logic [7:0]  name_data,
    output logic [7:0]  name,
    output logic [2:0]  row,
    output logic [2:0]  column,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        blank,
    output logic        vblank_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned HS_BEG  = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END  = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int unsigned VS_BEG  = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END  = V_VISIBLE + V_FRONT + V_SYNC;

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic [8:0]    sx;
    logic [8:0]    sy;
    logic          h_last;
    logic          v_last;
    logic [8:0]    px_x;
    logic [8:0]    px_y;

    // stage-0 timing flags and the one-stage-delayed copies
    logic hs0_n, vs0_n, bl0, vb0;
    logic hs1_n, vs1_n, bl1, vb1;

    assign h_last = (hcount == HW'(H_TOTAL - 1));
    assign v_last = (vcount == VW'(V_TOTAL - 1));

    // Raster counters: hcount every clock, vcount on line wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (h_last) begin
            hcount <= '0;
            vcount <= v_last ? '0 : vcount + VW'(1);
        end else begin
            hcount <= hcount + HW'(1);
        end
    end

    // Scroll offsets are sampled only on the last pixel of a frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sx <= '0;
            sy <= '0;
        end else if (h_last && v_last) begin
            sx <= scroll_x;
            sy <= scroll_y;
        end
    end

    // Stage 0: scrolled pixel position (9-bit wrap) and name-table address
    always_comb begin
        px_x      = 9'(hcount) + sx;
        px_y      = 9'(vcount) + sy;
        name_addr = {px_y[8:3], px_x[8:3]};
        hs0_n     = !((hcount >= HW'(HS_BEG)) && (hcount < HW'(HS_END)));
        vs0_n     = !((vcount >= VW'(VS_BEG)) && (vcount < VW'(VS_END)));
        bl0       = (hcount >= HW'(H_VISIBLE)) || (vcount >= VW'(V_VISIBLE));
        vb0       = (hcount == '0) && (vcount == VW'(V_VISIBLE));
    end

    // Tile number arrives from the registered name RAM in step with row/column
    assign name = name_data;

    // Stage 1: pixel-within-tile coordinates and first timing delay
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row    <= '0;
            column <= '0;
            hs1_n  <= 1'b1;
            vs1_n  <= 1'b1;
            bl1    <= 1'b1;
            vb1    <= 1'b0;
        end else begin
            row    <= px_y[2:0];
            column <= px_x[2:0];
            hs1_n  <= hs0_n;
            vs1_n  <= vs0_n;
            bl1    <= bl0;
            vb1    <= vb0;
        end
    end

    // Stage 2: timing outputs aligned with the tile RAM pixel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_n      <= 1'b1;
            vsync_n      <= 1'b1;
            blank        <= 1'b1;
            vblank_start <= 1'b0;
        end else begin
            hsync_n      <= hs1_n;
            vsync_n      <= vs1_n;
            blank        <= bl1;
            vblank_start <= vb1;
        end
    end

endmodule

// File: tb/tb_tile_scanner.sv
// Bench for tile_scanner on a reduced raster (360x32) so several frames fit in a short run.
// Expected outputs come from a pixel-index model: pixel k of the run maps to frame/line/column
// by division, with one latched scroll pair per frame.
module tb_tile_scanner;

    localparam int HV = 320, HF = 8, HS = 16, HB = 16;
    localparam int VV = 24, VF = 2, VS = 2, VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic [11:0] addr;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        vb;
    } pix_t;

    logic        clk;
    logic        reset_n;
    logic [8:0]  scroll_x;
    logic [8:0]  scroll_y;
    logic [11:0] name_addr;
    logic [7:0]  name_data;
    logic [7:0]  name;
    logic [2:0]  row;
    logic [2:0]  column;
    logic        hsync_n;
    logic        vsync_n;
    logic        blank;
    logic        vblank_start;

    int checks = 0;
    int errors = 0;
    int n;
    int vb_count = 0;
    logic [8:0] fsx [0:7];
    logic [8:0] fsy [0:7];

    tile_scanner #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .scroll_x(scroll_x), .scroll_y(scroll_y),
        .name_addr(name_addr), .name_data(name_data),
        .name(name), .row(row), .column(column),
        .hsync_n(hsync_n), .vsync_n(vsync_n),
        .blank(blank), .vblank_start(vblank_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ram_f(input logic [11:0] a);
        return 8'(a ^ (a >> 4));
    endfunction

    // Name table model: registered read, one cycle latency
    always @(posedge clk) name_data <= ram_f(name_addr);

    // Edge counter since reset release plus per-frame scroll capture
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n      <= 0;
            fsx[0] <= '0;
            fsy[0] <= '0;
        end else begin
            if (n % FT == FT - 1) begin
                fsx[n / FT + 1] <= scroll_x;
                fsy[n / FT + 1] <= scroll_y;
            end
            n <= n + 1;
        end
    end

    // Expected stage-0 view of pixel index k; k<0 means the idle reset state
    function automatic pix_t pix(input int k);
        pix_t r;
        int f, p, h, v, xx, yy;
        if (k < 0) begin
            r = '{addr: 12'd0, row: 3'd0, col: 3'd0, hs: 1'b1, vs: 1'b1, bl: 1'b1, vb: 1'b0};
            return r;
        end
        f  = k / FT;
        p  = k % FT;
        h  = p % HT;
        v  = p / HT;
        xx = (h + int'(fsx[f])) % 512;
        yy = (v + int'(fsy[f])) % 512;
        r.addr = 12'((yy / 8) * 64 + xx / 8);
        r.row  = 3'(yy % 8);
        r.col  = 3'(xx % 8);
        r.hs   = !(h >= HV + HF && h < HV + HF + HS);
        r.vs   = !(v >= VV + VF && v < VV + VF + VS);
        r.bl   = (h >= HV) || (v >= VV);
        r.vb   = (h == 0) && (v == VV);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got 0x%0h expected 0x%0h", nm, n, act, exp);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        pix_t e0, e1, e2;
        if (reset_n && n >= 1) begin
            e0 = pix(n);
            e1 = pix(n - 1);
            e2 = pix(n - 2);
            chk("name_addr", 32'(name_addr), 32'(e0.addr));
            chk("row", 32'(row), 32'(e1.row));
            chk("column", 32'(column), 32'(e1.col));
            chk("name", 32'(name), 32'(ram_f(e1.addr)));
            chk("hsync_n", 32'(hsync_n), 32'(e2.hs));
            chk("vsync_n", 32'(vsync_n), 32'(e2.vs));
            chk("blank", 32'(blank), 32'(e2.bl));
            chk("vblank_start", 32'(vblank_start), 32'(e2.vb));
        end
    end

    // Pulse counter for vblank_start
    always @(negedge clk) if (reset_n && vblank_start === 1'b1) vb_count++;

    // Advance to the negedge where n equals k, with a cycle budget
    task automatic wait_n(input int k);
        int b;
        b = 0;
        while (n != k && b < 60000) begin
            @(negedge clk);
            b++;
        end
        if (n != k) begin
            errors++;
            $display("FAIL wait_n timeout target=%0d got n=%0d", k, n);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "timeout");
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        scroll_x = 9'd0;
        scroll_y = 9'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_blank", 32'(blank), 32'd1);
        chk("rst_addr", 32'(name_addr), 32'h000);
        reset_n = 1'b1;
        #1;
        chk("lit_addr_n0", 32'(name_addr), 32'h000);

        wait_n(1);
        chk("lit_blank_n1", 32'(blank), 32'd1);
        chk("lit_col_n1", 32'(column), 32'd0);
        wait_n(2);
        chk("lit_blank_n2", 32'(blank), 32'd0);
        chk("lit_col_n2", 32'(column), 32'd1);
        wait_n(7);
        chk("lit_addr_n7", 32'(name_addr), 32'h000);
        wait_n(8);
        chk("lit_addr_n8", 32'(name_addr), 32'h001);
        chk("lit_col_n8", 32'(column), 32'd7);
        wait_n(321);
        chk("lit_blank_last_vis", 32'(blank), 32'd0);
        wait_n(322);
        chk("lit_blank_hblank", 32'(blank), 32'd1);
        wait_n(329);
        chk("lit_hsync_pre", 32'(hsync_n), 32'd1);
        wait_n(330);
        chk("lit_hsync_first", 32'(hsync_n), 32'd0);
        wait_n(345);
        chk("lit_hsync_last", 32'(hsync_n), 32'd0);
        wait_n(346);
        chk("lit_hsync_post", 32'(hsync_n), 32'd1);

        // mid-frame scroll change must not affect the current frame
        wait_n(5000);
        #1;
        scroll_x = 9'd5;
        scroll_y = 9'd9;
        wait_n(5001);
        chk("lit_midframe_addr", 32'(name_addr), 32'h068);

        wait_n(8641);
        chk("lit_vbs_pre", 32'(vblank_start), 32'd0);
        wait_n(8642);
        chk("lit_vbs", 32'(vblank_start), 32'd1);
        wait_n(8643);
        chk("lit_vbs_post", 32'(vblank_start), 32'd0);
        wait_n(9361);
        chk("lit_vsync_pre", 32'(vsync_n), 32'd1);
        wait_n(9362);
        chk("lit_vsync_first", 32'(vsync_n), 32'd0);
        wait_n(10081);
        chk("lit_vsync_last", 32'(vsync_n), 32'd0);
        wait_n(10082);
        chk("lit_vsync_post", 32'(vsync_n), 32'd1);

        // new frame picks up the latched scroll
        wait_n(FT);
        chk("lit_scroll_addr", 32'(name_addr), 32'h040);
        wait_n(FT + 1);
        chk("lit_scroll_row", 32'(row), 32'd1);
        chk("lit_scroll_col", 32'(column), 32'd5);

        wait_n(FT + 5000);
        #1;
        scroll_x = 9'd500;
        scroll_y = 9'd0;
        wait_n(2 * FT + 11);
        chk("lit_tile63", 32'(name_addr), 32'h03F);
        wait_n(2 * FT + 12);
        chk("lit_wrap_tile0", 32'(name_addr), 32'h000);

        // asynchronous reset mid-line at hcount=300, vcount=20
        wait_n(2 * FT + 20 * HT + 300);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_hsync", 32'(hsync_n), 32'd1);
        chk("arst_vsync", 32'(vsync_n), 32'd1);
        chk("arst_blank", 32'(blank), 32'd1);
        chk("arst_vbs", 32'(vblank_start), 32'd0);
        chk("arst_addr", 32'(name_addr), 32'h000);
        chk("arst_row", 32'(row), 32'd0);
        chk("arst_col", 32'(column), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rel_addr_n0", 32'(name_addr), 32'h000);
        wait_n(2);
        chk("rel_blank_n2", 32'(blank), 32'd0);
        wait_n(12);
        chk("rel_addr_n12", 32'(name_addr), 32'h001);

        wait_n(FT + 9000);
        chk("vblank_count", 32'(vb_count), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
